// File: rtl/key_switch_conditioner_pkg.sv
// Shared constants for the KEY/SW conditioner: board sizes, clock rate and debounce timing.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package key_switch_conditioner_pkg;

    // Board population of push-buttons and slide switches.
    localparam int unsigned N_KEY_DEFAULT = 2;
    localparam int unsigned N_SW_DEFAULT  = 10;

    // System clock and the hold time an input must show before it is believed.
    localparam int unsigned CLK_HZ      = 10_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Idle (released / down) level of each raw input family as seen on the pins.
    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    // Counter width that holds 0 .. cycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : key_switch_conditioner_pkg

// File: rtl/key_switch_conditioner_debounce_cell.sv
// One-bit synchroniser + debouncer + edge detector for a raw asynchronous pin.
// Latency: a steady new value reaches level on the (DEBOUNCE_CYCLES+2)th edge; rise/fall pulse in that same cycle.
// Backpressure: none; the cell free-runs every cycle and pulses cannot be stalled.
module debounce_cell
    import key_switch_conditioner_pkg::*;
#(
    parameter logic        IDLE            = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic ADC_CLK_10,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1, after which it is cleared by acceptance.
    localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-flop synchroniser; resets to the idle pin level so release looks like no change.
    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            s1_q <= IDLE;
            s2_q <= IDLE;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce decision: any agreement with the stable value restarts the hold count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Debounce state and registered edge pulses; reset overrides any pending acceptance.
    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            stable_q <= IDLE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : debounce_cell

// File: rtl/key_switch_conditioner.sv
// Conditions raw board KEY (active-low) and SW pins into clean active-high levels and one-cycle edge pulses.
// Latency: a steady pin change is visible on the (DEBOUNCE_CYCLES+2)th rising edge after it is first sampled.
// Backpressure: none; outputs are level/pulse style and consumers must take pulses when they appear.
module key_switch_conditioner
    import key_switch_conditioner_pkg::*;
#(
    parameter int unsigned N_KEY           = N_KEY_DEFAULT,
    parameter int unsigned N_SW            = N_SW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             ADC_CLK_10,
    input  logic             reset,
    input  logic [N_KEY-1:0] KEY,
    input  logic [N_SW-1:0]  SW,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_change
);

    // Pin-polarity views straight out of the cells; KEY is still active-low here.
    logic [N_KEY-1:0] key_stable;
    logic [N_KEY-1:0] key_rise;
    logic [N_KEY-1:0] key_fall;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;

    genvar gk;
    generate
        for (gk = 0; gk < N_KEY; gk++) begin : g_key
            debounce_cell #(
                .IDLE            (KEY_IDLE),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cell (
                .ADC_CLK_10 (ADC_CLK_10),
                .reset      (reset),
                .raw        (KEY[gk]),
                .level      (key_stable[gk]),
                .rise       (key_rise[gk]),
                .fall       (key_fall[gk])
            );
        end
    endgenerate

    genvar gs;
    generate
        for (gs = 0; gs < N_SW; gs++) begin : g_sw
            debounce_cell #(
                .IDLE            (SW_IDLE),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cell (
                .ADC_CLK_10 (ADC_CLK_10),
                .reset      (reset),
                .raw        (SW[gs]),
                .level      (sw_level[gs]),
                .rise       (sw_rise[gs]),
                .fall       (sw_fall[gs])
            );
        end
    endgenerate

    // A pin falling to 0 is a press; the stable reset value 1 therefore reads as released.
    assign key_level   = ~key_stable;
    assign key_press   = key_fall;
    assign key_release = key_rise;

    // Switch consumers only care that the position moved, not which way.
    assign sw_change   = sw_rise | sw_fall;

endmodule : key_switch_conditioner

// File: tb/tb_key_switch_conditioner.sv
module tb_key_switch_conditioner;

    localparam int D     = 4;
    localparam int NK    = 2;
    localparam int NS    = 10;
    localparam int NB    = NK + NS;
    localparam logic [NB-1:0] IDLE_V = 12'h003;

    logic          clk;
    logic          reset;
    logic [NK-1:0] KEY;
    logic [NS-1:0] SW;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NS-1:0] sw_level;
    logic [NS-1:0] sw_change;

    int errors = 0;
    int checks = 0;

    key_switch_conditioner #(
        .N_KEY           (NK),
        .N_SW            (NS),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .ADC_CLK_10  (clk),
        .reset       (reset),
        .KEY         (KEY),
        .SW          (SW),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: an input is accepted once the last D synchronised samples all
    // disagree with the accepted value. Synchronised sample at an edge = raw sampled two edges earlier.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_stable;
    logic [NB-1:0] m_rise;
    logic [NB-1:0] m_fall;

    always @(posedge clk) begin : model
        automatic logic [NB-1:0] acc;
        automatic logic [NB-1:0] raw_v;
        raw_v = {SW, KEY};
        if (reset) begin
            hist.delete();
            hist.push_back(IDLE_V);
            hist.push_back(IDLE_V);
            m_stable <= IDLE_V;
            m_rise   <= '0;
            m_fall   <= '0;
        end else begin
            acc = '0;
            if (hist.size() >= D + 1) begin
                acc = '1;
                for (int k = 0; k < D; k++) begin
                    acc = acc & (hist[hist.size() - 2 - k] ^ m_stable);
                end
            end
            m_rise   <= acc & ~m_stable;
            m_fall   <= acc & m_stable;
            m_stable <= m_stable ^ acc;
            hist.push_back(raw_v);
            if (hist.size() > D + 2) begin
                void'(hist.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [35:0] all;
        reset = 1'b1;
        KEY   = 2'b11;
        SW    = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            all = {key_level, key_press, key_release, sw_level, sw_change};
            checks++;
            if (all !== '0) begin
                errors++;
                $display("FAIL reset_hold edge=%0d got=%h want=0", k, all);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            all = {key_level, key_press, key_release, sw_level, sw_change};
            checks++;
            if (all !== '0) begin
                errors++;
                $display("FAIL reset_idle edge=%0d got=%h want=0", k, all);
            end
        end
    endtask

    task automatic test_clean_press();
        logic exp;
        KEY[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k == 6);
            checks++;
            if (key_press[0] !== exp) begin
                errors++;
                $display("FAIL press_pulse edge=%0d got=%b want=%b", k, key_press[0], exp);
            end
            exp = (k >= 6);
            checks++;
            if (key_level[0] !== exp) begin
                errors++;
                $display("FAIL press_level edge=%0d got=%b want=%b", k, key_level[0], exp);
            end
        end
        KEY[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k == 6);
            checks++;
            if (key_release[0] !== exp) begin
                errors++;
                $display("FAIL release_pulse edge=%0d got=%b want=%b", k, key_release[0], exp);
            end
            exp = (k < 6);
            checks++;
            if (key_level[0] !== exp) begin
                errors++;
                $display("FAIL release_level edge=%0d got=%b want=%b", k, key_level[0], exp);
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 28; c++) begin
            KEY[1] = (c < 20) ? (((c / 2) % 2) == 1) : 1'b1;
            step();
            checks++;
            if ({key_press[1], key_release[1], key_level[1]} !== 3'b000) begin
                errors++;
                $display("FAIL bounce cycle=%0d got press/rel/level=%b%b%b want=000",
                         c, key_press[1], key_release[1], key_level[1]);
            end
        end
    endtask

    task automatic test_sw_at_reset();
        logic exp;
        reset = 1'b1;
        SW[0] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k == 6);
            checks++;
            if (sw_change !== {9'b0, exp}) begin
                errors++;
                $display("FAIL sw_reset_change edge=%0d got=%h want=%h", k, sw_change, {9'b0, exp});
            end
            exp = (k >= 6);
            checks++;
            if (sw_level[0] !== exp) begin
                errors++;
                $display("FAIL sw_reset_level edge=%0d got=%b want=%b", k, sw_level[0], exp);
            end
        end
        SW = '0;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_reset_mid();
        logic exp;
        KEY[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (key_press[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_early edge=%0d got=%b want=0", k, key_press[0]);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({key_press, key_level} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_during got=%b want=0000", {key_press, key_level});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k == 6);
            checks++;
            if (key_press[0] !== exp) begin
                errors++;
                $display("FAIL midreset_press edge=%0d got=%b want=%b", k, key_press[0], exp);
            end
        end
        KEY = 2'b11;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_parallel();
        logic [NS-1:0] exp_sw;
        logic [NK-1:0] exp_k;
        SW  = 10'h3FF;
        KEY = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_sw = (k == 6) ? 10'h3FF : 10'h000;
            exp_k  = (k == 6) ? 2'b11 : 2'b00;
            checks++;
            if (sw_change !== exp_sw) begin
                errors++;
                $display("FAIL parallel_sw edge=%0d got=%h want=%h", k, sw_change, exp_sw);
            end
            checks++;
            if (key_press !== exp_k) begin
                errors++;
                $display("FAIL parallel_key edge=%0d got=%b want=%b", k, key_press, exp_k);
            end
        end
        checks++;
        if ({sw_level, key_level} !== 12'hFFF) begin
            errors++;
            $display("FAIL parallel_level got=%h want=fff", {sw_level, key_level});
        end
    endtask

    task automatic test_random();
        int rate;
        rate = 6;
        for (int c = 0; c < 2000; c++) begin
            if ((c % 64) == 0) rate = $urandom_range(2, 14);
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NK; i++) if ($urandom_range(0, rate - 1) == 0) KEY[i] = ~KEY[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(0, rate - 1) == 0) SW[i] = ~SW[i];
            step();
            checks++;
            if (key_level !== ~m_stable[NK-1:0]) begin
                errors++;
                $display("FAIL rnd_key_level cyc=%0d got=%b want=%b", c, key_level, ~m_stable[NK-1:0]);
            end
            checks++;
            if (key_press !== m_fall[NK-1:0]) begin
                errors++;
                $display("FAIL rnd_key_press cyc=%0d got=%b want=%b", c, key_press, m_fall[NK-1:0]);
            end
            checks++;
            if (key_release !== m_rise[NK-1:0]) begin
                errors++;
                $display("FAIL rnd_key_release cyc=%0d got=%b want=%b", c, key_release, m_rise[NK-1:0]);
            end
            checks++;
            if (sw_level !== m_stable[NB-1:NK]) begin
                errors++;
                $display("FAIL rnd_sw_level cyc=%0d got=%h want=%h", c, sw_level, m_stable[NB-1:NK]);
            end
            checks++;
            if (sw_change !== (m_rise[NB-1:NK] | m_fall[NB-1:NK])) begin
                errors++;
                $display("FAIL rnd_sw_change cyc=%0d got=%h want=%h", c, sw_change,
                         m_rise[NB-1:NK] | m_fall[NB-1:NK]);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 2'b11;
        SW    = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sw_at_reset();
        test_reset_mid();
        test_parallel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
